// File: rtl/card_draw_sched.sv
// card_draw_sched: round-robin card-draw arbiter; draws 1..13 from a free-running counter, then waits DELAY_TICKS ticks.
module card_draw_sched #(
  parameter int WIDTH       = 12,
  parameter int DELAY_TICKS = 4000
) (
  input  logic             clk_50M,
  input  logic             i_Reset,
  input  logic             i_Tick2K,
  input  logic             i_ReqPlayer,
  input  logic             i_ReqDealer,
  output logic             o_GntPlayer,
  output logic             o_GntDealer,
  output logic [3:0]       o_Card,
  output logic             o_Busy,
  output logic             o_TwoSec,
  output logic [WIDTH-1:0] o_Count
);
  localparam int TW = $clog2(DELAY_TICKS + 1);
  typedef enum logic [1:0] {IDLE, GRANT, WAIT} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] cnt_q;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0] card_q, card_d;
  logic win_q, win_d, pri_q, pri_d;
  logic done;
  // win/pri: 1 selects the dealer
  always_comb begin
    done = state_q == WAIT && i_Tick2K && tick_q == TW'(DELAY_TICKS - 1);
    state_d = state_q;
    tick_d = tick_q;
    card_d = card_q;
    win_d = win_q;
    pri_d = pri_q;
    case (state_q)
      IDLE: if (i_ReqPlayer || i_ReqDealer) begin
        state_d = GRANT;
        win_d = i_ReqDealer & (~i_ReqPlayer | pri_q);
        card_d = 4'(cnt_q % WIDTH'(13)) + 4'd1;
      end
      GRANT: begin
        state_d = WAIT;
        tick_d = '0;
        pri_d = ~win_q;
      end
      WAIT: begin
        state_d = done ? IDLE : WAIT;
        tick_d = done ? '0 : tick_q + TW'(i_Tick2K);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_50M) begin
    if (i_Reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      tick_q <= '0;
      card_q <= '0;
      win_q <= 1'b0;
      pri_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_q + 1'b1;
      tick_q <= tick_d;
      card_q <= card_d;
      win_q <= win_d;
      pri_q <= pri_d;
    end
  end
  assign o_GntPlayer = state_q == GRANT && !win_q;
  assign o_GntDealer = state_q == GRANT && win_q;
  assign o_Busy = state_q != IDLE;
  assign o_TwoSec = done;
  assign o_Card = card_q;
  assign o_Count = cnt_q;
endmodule

// File: tb/tb_card_draw_sched.sv
// tb_card_draw_sched: directed scenarios plus random traffic against a cycle-level reference model.
module tb_card_draw_sched;
  logic clk_50M = 1'b0;
  logic rst = 1'b1;
  logic p0 = 1'b0, d0 = 1'b0, t0 = 1'b0;
  logic p1 = 1'b0, d1 = 1'b0, t1 = 1'b0;
  logic gp0, gd0, bz0, ts0, gp1, gd1, bz1, ts1;
  logic [3:0] c0, c1;
  logic [11:0] n0;
  logic [3:0] n1;
  int checks = 0;
  int errors = 0;
  bit armed = 0;
  always #10 clk_50M = ~clk_50M;
  card_draw_sched #(.WIDTH(12), .DELAY_TICKS(3)) u0 (
    .clk_50M(clk_50M), .i_Reset(rst), .i_Tick2K(t0), .i_ReqPlayer(p0), .i_ReqDealer(d0),
    .o_GntPlayer(gp0), .o_GntDealer(gd0), .o_Card(c0), .o_Busy(bz0), .o_TwoSec(ts0), .o_Count(n0));
  card_draw_sched #(.WIDTH(4), .DELAY_TICKS(1)) u1 (
    .clk_50M(clk_50M), .i_Reset(rst), .i_Tick2K(t1), .i_ReqPlayer(p1), .i_ReqDealer(d1),
    .o_GntPlayer(gp1), .o_GntDealer(gd1), .o_Card(c1), .o_Busy(bz1), .o_TwoSec(ts1), .o_Count(n1));
  // mode: 0 idle, 1 granting, 2 waiting; left = ticks still needed
  typedef struct {int cnt; int mode; bit dealer; bit dealer_pri; int card; int left;} mdl_t;
  mdl_t m0 = '{default: 0};
  mdl_t m1 = '{default: 0};
  function automatic mdl_t nxt(mdl_t m, bit r, bit p, bit d, bit t, int w, int dt);
    mdl_t n = m;
    if (r) begin
      n = '{cnt: 0, mode: 0, dealer: 0, dealer_pri: 0, card: 0, left: dt};
      return n;
    end
    n.cnt = (m.cnt + 1) % (1 << w);
    if (m.mode == 0 && (p || d)) begin
      n.dealer = (p && d) ? m.dealer_pri : d;
      n.card = m.cnt % 13 + 1;
      n.mode = 1;
    end else if (m.mode == 1) begin
      n.dealer_pri = !m.dealer;
      n.mode = 2;
      n.left = dt;
    end else if (m.mode == 2 && t) begin
      n.left = m.left - 1;
      if (n.left == 0) n.mode = 0;
    end
    return n;
  endfunction
  task automatic expect_v(string tag, logic [11:0] got, logic [11:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic chk(string tag, mdl_t m, bit t, logic gp, logic gd, logic [3:0] cd, logic bz, logic ts, int cnt);
    expect_v({tag, ".gnt_player"}, {11'd0, gp}, {11'd0, m.mode == 1 && !m.dealer});
    expect_v({tag, ".gnt_dealer"}, {11'd0, gd}, {11'd0, m.mode == 1 && m.dealer});
    expect_v({tag, ".busy"}, {11'd0, bz}, {11'd0, m.mode != 0});
    expect_v({tag, ".two_sec"}, {11'd0, ts}, {11'd0, m.mode == 2 && t && m.left == 1});
    expect_v({tag, ".card"}, {8'd0, cd}, 12'(m.card));
    expect_v({tag, ".count"}, 12'(cnt), 12'(m.cnt));
  endtask
  task automatic half();
    @(negedge clk_50M);
    if (armed) begin
      chk("u0", m0, t0, gp0, gd0, c0, bz0, ts0, int'(n0));
      chk("u1", m1, t1, gp1, gd1, c1, bz1, ts1, int'(n1));
      if (gp1 || gd1) expect_v("u1.card_range", {11'd0, c1 >= 4'd1 && c1 <= 4'd13}, 12'd1);
    end
  endtask
  task automatic fin();
    @(posedge clk_50M);
    m0 = nxt(m0, rst, p0, d0, t0, 12, 3);
    m1 = nxt(m1, rst, p1, d1, t1, 4, 1);
    if (rst) armed = 1;
    #1;
    p1 = $urandom_range(0, 1);
    d1 = $urandom_range(0, 1);
    t1 = $urandom_range(0, 2) == 0;
  endtask
  task automatic cyc();
    half();
    fin();
  endtask
  task automatic wait_gnt(string tag, bit dealer);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      half();
      if (gp0 || gd0) begin
        seen = 1;
        expect_v({tag, ".who"}, {10'd0, gd0, gp0}, dealer ? 12'd2 : 12'd1);
      end
      fin();
    end
    if (!seen) begin
      checks++;
      errors++;
      $error("FAIL %s got no grant expected grant within 20 cycles", tag);
    end
  endtask
  initial begin
    cyc();
    cyc();
    rst = 1'b0;
    half();
    expect_v("rst.busy", {11'd0, bz0}, 12'd0);
    expect_v("rst.count", n0, 12'd0);
    expect_v("rst.card", {8'd0, c0}, 12'd0);
    fin();
    for (int i = 0; i < 100 && m0.cnt != 25; i++) cyc();
    p0 = 1'b1;
    cyc();
    p0 = 1'b0;
    t0 = 1'b1;
    half();
    expect_v("s1.gnt_player", {11'd0, gp0}, 12'd1);
    expect_v("s1.card", {8'd0, c0}, 12'd13);
    expect_v("s1.busy", {11'd0, bz0}, 12'd1);
    fin();
    half();
    expect_v("s3.tick1_two_sec", {11'd0, ts0}, 12'd0);
    fin();
    t0 = 1'b0;
    cyc();
    t0 = 1'b1;
    cyc();
    half();
    expect_v("s3.tick3_two_sec", {11'd0, ts0}, 12'd1);
    fin();
    t0 = 1'b0;
    half();
    expect_v("s3.busy_fall", {11'd0, bz0}, 12'd0);
    fin();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    p0 = 1'b1;
    d0 = 1'b1;
    t0 = 1'b1;
    wait_gnt("rr1", 0);
    wait_gnt("rr2", 1);
    wait_gnt("rr3", 0);
    p0 = 1'b0;
    d0 = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    t0 = 1'b0;
    p0 = 1'b1;
    wait_gnt("s4.setup", 0);
    p0 = 1'b0;
    d0 = 1'b1;
    cyc();
    cyc();
    d0 = 1'b0;
    t0 = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    t0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      half();
      expect_v("s4.no_gnt", {10'd0, gd0, gp0}, 12'd0);
      fin();
    end
    p0 = 1'b1;
    wait_gnt("s5.setup", 0);
    p0 = 1'b0;
    t0 = 1'b1;
    cyc();
    cyc();
    t0 = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    half();
    expect_v("s5.outs", {5'd0, gp0, gd0, c0, bz0, ts0}, 12'd0);
    expect_v("s5.count", n0, 12'd0);
    fin();
    t0 = 1'b1;
    cyc();
    cyc();
    t0 = 1'b0;
    p0 = 1'b1;
    wait_gnt("s5.regrant", 0);
    p0 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bit wrap = m1.cnt == 15;
      cyc();
      if (wrap) begin
        half();
        expect_v("s6.wrap", {8'd0, n1}, 12'd0);
        fin();
      end
    end
    for (int i = 0; i < 2500; i++) begin
      rst = $urandom_range(0, 299) == 0;
      p0 = $urandom_range(0, 1);
      d0 = $urandom_range(0, 1);
      t0 = $urandom_range(0, 3) == 0;
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
